rr_sched8: RTL and testbench

Round-robin scheduler that shares one 1-bit output channel between eight requesters by driving the 3-bit select of the team's 8:1 mux. It grants one requester at a time, holds the grant for a bounded burst of accepted beats, and presents the selected data to a downstream ready/valid consumer. It sits between the eight data sources and the shared serial sink.

---
 rtl/rr_sched_pkg.sv | 14 +
 rtl/mux81.sv | 13 +
 rtl/rr_pick8.sv | 31 +++
 rtl/rr_sched8.sv | 109 ++++++++++
 tb/tb_rr_sched8.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_sched_pkg.sv
// Shared constants and state type for the eight-way round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : rr_sched_pkg

// File: rtl/mux81.sv
// Generic 8:1 single-bit multiplexer used as the scheduler data path.
// Latency: combinational.
// Backpressure: none; pure select.
// Ports: d_i[7:0] data inputs, sel_i[2:0] select, y_o selected bit.
module mux81 (
  input  logic [7:0] d_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);

  assign y_o = d_i[sel_i];

endmodule : mux81

// File: rtl/rr_pick8.sv
// Rotate-priority picker: first set bit of req_i scanning ptr_i, ptr_i+1, ... mod 8.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: req_i[7:0] requests, ptr_i[2:0] scan start, found_o any request, idx_o winner index.
module rr_pick8
  import rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit to ptr_i
  // is the last assignment and therefore wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

  assign found_o = |req_i;

endmodule : rr_pick8

// File: rtl/rr_sched8.sv
// Round-robin scheduler sharing one serial bit between eight requesters, bounded bursts.
// Latency: grant registers one edge after req seen in IDLE; one IDLE bubble after every grant.
// Backpressure: out_ready low holds the grant and beat count indefinitely; a req drop releases.
// Ports: clk, rst (sync, active-high); req[7:0], d[7:0] from sources; gnt[7:0] one-hot,
//        sel[2:0] mux select; y = d[sel]; out_valid/out_ready handshake to the sink.
module rr_sched8
  import rr_sched_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int                CNT_W    = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             beat;

  rr_pick8 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  mux81 u_mux (
    .d_i   (d),
    .sel_i (sel_q),
    .y_o   (y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d         = BUSY;
          sel_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          cnt_d           = '0;
        end
      end
      BUSY: begin
        // Release on a dropped request or on the last beat of the burst.
        // sel is left as-is so y keeps tracking the last granted source.
        if (!req[sel_q] || (beat && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == BUSY) && req[sel_q];
    beat      = out_valid && out_ready;
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule : rr_sched8

// File: tb/tb_rr_sched8.sv
// Self-checking bench for rr_sched8: table-driven first-grant vectors plus
// hand-written multi-cycle sequences, expectations routed through a scoreboard queue.
// Two instances: BURST=4 (main) and BURST=1 (fairness/wrap).
module tb_rr_sched8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] d = 8'h00;

  logic [7:0] gnt, gnt1;
  logic [2:0] sel, sel1;
  logic       y, y1, ov, ov1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
  } exp_t;

  exp_t exp_q[$];
  int   order_q[$];
  vec_t vecs[6];

  rr_sched8 #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
    .gnt       (gnt),
    .sel       (sel),
    .y         (y),
    .out_valid (ov),
    .out_ready (out_ready)
  );

  rr_sched8 #(.BURST(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
    .gnt       (gnt1),
    .sel       (sel1),
    .y         (y1),
    .out_valid (ov1),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] g, input logic [2:0] s, input logic yy);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    e.y   = yy;
    exp_q.push_back(e);
  endtask

  // Pop the next expected grant and compare against the BURST=4 instance.
  task automatic sb_check(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_gnt"}, 32'(gnt), 32'(e.gnt));
      chk({nm, "_sel"}, 32'(sel), 32'(e.sel));
      chk({nm, "_y"}, 32'(y), 32'(e.y));
      chk({nm, "_valid"}, 32'(ov), 32'd1);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_idle_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_idle_valid"}, 32'(ov), 32'd0);
  endtask

  initial begin
    logic [7:0] pats[2];
    logic [2:0] pexp[2];
    int idx;

    vecs[0] = '{req: 8'h01, d: 8'h01, gnt: 8'h01, sel: 3'd0, y: 1'b1};
    vecs[1] = '{req: 8'h80, d: 8'h00, gnt: 8'h80, sel: 3'd7, y: 1'b0};
    vecs[2] = '{req: 8'h0C, d: 8'h04, gnt: 8'h04, sel: 3'd2, y: 1'b1};
    vecs[3] = '{req: 8'hA0, d: 8'h20, gnt: 8'h20, sel: 3'd5, y: 1'b1};
    vecs[4] = '{req: 8'h12, d: 8'hED, gnt: 8'h02, sel: 3'd1, y: 1'b0};
    vecs[5] = '{req: 8'hFF, d: 8'hFF, gnt: 8'h01, sel: 3'd0, y: 1'b1};

    // Reset state
    cyc();
    do_reset();
    d = 8'hFE;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_y0", 32'(y), 32'd0);
    d = 8'h01;
    #1;
    chk("rst_y1", 32'(y), 32'd1);

    // First grant from ptr=0 for assorted request patterns
    for (int i = 0; i < 6; i++) begin
      do_reset();
      out_ready = 1'b0;
      req = vecs[i].req;
      d   = vecs[i].d;
      push_exp(vecs[i].gnt, vecs[i].sel, vecs[i].y);
      #1;
      chk_idle($sformatf("vec%0d", i));
      cyc();
      sb_check($sformatf("vec%0d", i));
    end

    // Single requester, BURST=4: 4 beats, one bubble, re-grant
    do_reset();
    req = 8'h08;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      #1;
      chk_idle($sformatf("single_r%0d", r));
      cyc();
      for (int b = 0; b < 4; b++) begin
        d = (b % 2 == 1) ? 8'h08 : 8'h00;
        push_exp(8'h08, 3'd3, (b % 2 == 1));
        #1;
        sb_check($sformatf("single_r%0d_b%0d", r, b));
        cyc();
      end
    end
    #1;
    chk_idle("single_end");

    // Fairness with wrap on the BURST=1 instance
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) order_q.push_back(k % 8);
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("fair%0d_idle_gnt", k), 32'(gnt1), 32'd0);
      chk($sformatf("fair%0d_idle_valid", k), 32'(ov1), 32'd0);
      cyc();
      idx = order_q.pop_front();
      chk($sformatf("fair%0d_sel", k), 32'(sel1), 32'(idx));
      chk($sformatf("fair%0d_gnt", k), 32'(gnt1), 32'd1 << idx);
      chk($sformatf("fair%0d_valid", k), 32'(ov1), 32'd1);
      cyc();
    end

    // Early release of port 5 after one beat; scan resumes at 6
    pats[0] = 8'h21; pexp[0] = 3'd0;
    pats[1] = 8'hC1; pexp[1] = 3'd6;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      req = 8'h20;
      out_ready = 1'b1;
      d = 8'h20;
      cyc();
      push_exp(8'h20, 3'd5, 1'b1);
      sb_check($sformatf("early%0d_beat", p));
      cyc();
      req = 8'h01;
      #1;
      chk($sformatf("early%0d_drop_valid", p), 32'(ov), 32'd0);
      chk($sformatf("early%0d_drop_gnt", p), 32'(gnt), 32'h20);
      cyc();
      chk_idle($sformatf("early%0d_rel", p));
      req = pats[p];
      d = 8'h00;
      cyc();
      push_exp(8'h01 << pexp[p], pexp[p], 1'b0);
      sb_check($sformatf("early%0d_next", p));
    end

    // Backpressure: stall 10 cycles after one beat, then 3 remaining beats
    do_reset();
    req = 8'h02;
    d = 8'h02;
    out_ready = 1'b1;
    cyc();
    push_exp(8'h02, 3'd1, 1'b1);
    sb_check("bp_first");
    cyc();
    out_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      #1;
      push_exp(8'h02, 3'd1, 1'b1);
      sb_check($sformatf("bp_stall%0d", s));
      cyc();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      push_exp(8'h02, 3'd1, 1'b1);
      sb_check($sformatf("bp_rest%0d", b));
      cyc();
    end
    #1;
    chk_idle("bp_end");

    // Reset mid-burst after two beats of port 2
    do_reset();
    req = 8'h04;
    d = 8'h04;
    out_ready = 1'b1;
    cyc();
    push_exp(8'h04, 3'd2, 1'b1);
    sb_check("mid_b0");
    cyc();
    push_exp(8'h04, 3'd2, 1'b1);
    sb_check("mid_b1");
    cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_valid", 32'(ov), 32'd0);
    rst = 1'b0;
    req = 8'h24;
    d = 8'h00;
    #1;
    chk("mid_idle_valid", 32'(ov), 32'd0);
    cyc();
    push_exp(8'h04, 3'd2, 1'b0);
    sb_check("mid_regrant");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_sched8
